// File: rtl/dcpu_uart_pkg.sv
// Shared definitions for the dcpu UART peripheral: register map, bit
// positions inside STATUS/CTRL, the serial FSM state type and the
// half-bit reload helper used by the receiver.
package dcpu_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int STAT_RX_AVAIL     = 0;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_TX_FULL      = 3;
    localparam int STAT_RX_OVERRUN   = 4;
    localparam int STAT_RX_FRAME_ERR = 5;

    localparam int CTRL_RX_INT_EN = 0;
    localparam int CTRL_TX_INT_EN = 1;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    // The bit counters fire when they reach zero, so a reload of N gives a
    // period of N+1 clocks. Half a bit is (div+1)/2 clocks, computed in 17
    // bits so that div = 16'hFFFF does not wrap.
    function automatic logic [15:0] halfBit(input logic [15:0] div);
        logic [16:0] clocks;
        clocks = ({1'b0, div} + 17'd1) >> 1;
        return (clocks == 17'd0) ? 16'd0 : 16'(clocks - 17'd1);
    endfunction

endpackage

// File: rtl/dcpu_fifo.sv
// Small synchronous FIFO with a combinational head. A push into a full
// FIFO is dropped even if a pop happens in the same cycle; a pop from an
// empty FIFO is ignored.
module dcpu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign dout_o  = mem_q[rdPtr_q];

    // Storage array; contents are don't-care while the slot is not occupied.
    always_ff @(posedge i_clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dcpu_uart.sv
// Memory-mapped console UART for the dcpu data bus. Four word registers
// (DATA, STATUS, CTRL, DIV), a TX and an RX FIFO, and a level interrupt.
// Bus reads are combinational so the CPU can sample them in the same cycle.
module dcpu_uart #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic [1:0]  i_addr,
    input  logic        i_rw,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    output logic        o_int,
    input  logic        i_rx,
    output logic        o_tx
);

    import dcpu_uart_pkg::*;

    logic        rdAccess;
    logic        wrAccess;
    logic [1:0]  ctrl_q;
    logic [15:0] div_q;
    logic        overrun_q;
    logic        frameErr_q;

    logic        txPush, txPop, txEmpty, txFull, txIdleEmpty;
    logic [7:0]  txHead;
    logic        rxPush, rxPop, rxEmpty, rxFull;
    logic [7:0]  rxHead;

    uart_state_e txState_q;
    logic [15:0] txCnt_q;
    logic [2:0]  txBit_q;
    logic [7:0]  txShift_q;
    logic        txOut_q;
    logic        txTick;

    logic        rxMeta_q, rxSync_q, rxPrev_q;
    uart_state_e rxState_q;
    logic [15:0] rxCnt_q;
    logic [2:0]  rxBit_q;
    logic [7:0]  rxShift_q;
    logic        rxTick;
    logic        rxStopSample;

    assign rdAccess = i_cs && i_rw;
    assign wrAccess = i_cs && !i_rw;

    assign txPush      = wrAccess && (i_addr == REG_DATA);
    assign txPop       = (txState_q == UART_IDLE) && !txEmpty;
    assign txTick      = (txCnt_q == 16'd0);
    assign txIdleEmpty = txEmpty && (txState_q == UART_IDLE);

    assign rxPop        = rdAccess && (i_addr == REG_DATA);
    assign rxTick       = (rxCnt_q == 16'd0);
    assign rxStopSample = (rxState_q == UART_STOP) && rxTick;
    assign rxPush       = rxStopSample && rxSync_q;

    assign o_tx  = txOut_q;
    assign o_int = (ctrl_q[CTRL_RX_INT_EN] && !rxEmpty) ||
                   (ctrl_q[CTRL_TX_INT_EN] && txIdleEmpty);

    dcpu_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push_i  (txPush),
        .pop_i   (txPop),
        .din_i   (i_dat[7:0]),
        .dout_o  (txHead),
        .empty_o (txEmpty),
        .full_o  (txFull)
    );

    dcpu_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push_i  (rxPush),
        .pop_i   (rxPop),
        .din_i   (rxShift_q),
        .dout_o  (rxHead),
        .empty_o (rxEmpty),
        .full_o  (rxFull)
    );

    // Software-visible configuration registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ctrl_q <= 2'b00;
            div_q  <= DIV_RESET;
        end else if (wrAccess) begin
            if (i_addr == REG_CTRL) begin
                ctrl_q <= i_dat[1:0];
            end
            if (i_addr == REG_DIV) begin
                div_q <= i_dat;
            end
        end
    end

    // Sticky receive error flags; a new error in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            if (wrAccess && (i_addr == REG_STATUS)) begin
                if (i_dat[STAT_RX_OVERRUN]) begin
                    overrun_q <= 1'b0;
                end
                if (i_dat[STAT_RX_FRAME_ERR]) begin
                    frameErr_q <= 1'b0;
                end
            end
            if (rxPush && rxFull) begin
                overrun_q <= 1'b1;
            end
            if (rxStopSample && !rxSync_q) begin
                frameErr_q <= 1'b1;
            end
        end
    end

    // Transmitter: start bit, eight data bits LSB first, stop bit. The bit
    // counter reloads from DIV at every bit boundary, so a DIV change lands
    // on the next boundary.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            txState_q <= UART_IDLE;
            txCnt_q   <= 16'd0;
            txBit_q   <= 3'd0;
            txShift_q <= 8'h00;
            txOut_q   <= 1'b1;
        end else begin
            case (txState_q)
                UART_IDLE: begin
                    txOut_q <= 1'b1;
                    if (!txEmpty) begin
                        txShift_q <= txHead;
                        txCnt_q   <= div_q;
                        txOut_q   <= 1'b0;
                        txState_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (txTick) begin
                        txOut_q   <= txShift_q[0];
                        txShift_q <= {1'b0, txShift_q[7:1]};
                        txBit_q   <= 3'd0;
                        txCnt_q   <= div_q;
                        txState_q <= UART_DATA;
                    end else begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end
                end
                UART_DATA: begin
                    if (txTick) begin
                        txCnt_q <= div_q;
                        if (txBit_q == 3'd7) begin
                            txOut_q   <= 1'b1;
                            txState_q <= UART_STOP;
                        end else begin
                            txOut_q   <= txShift_q[0];
                            txShift_q <= {1'b0, txShift_q[7:1]};
                            txBit_q   <= txBit_q + 1'b1;
                        end
                    end else begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end
                end
                UART_STOP: begin
                    if (txTick) begin
                        txState_q <= UART_IDLE;
                    end else begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous line plus an edge-detect flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= i_rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Receiver: wait for a falling edge, confirm the start bit at half a bit,
    // then sample each data bit and the stop bit at mid-bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rxState_q <= UART_IDLE;
            rxCnt_q   <= 16'd0;
            rxBit_q   <= 3'd0;
            rxShift_q <= 8'h00;
        end else begin
            case (rxState_q)
                UART_IDLE: begin
                    if (rxPrev_q && !rxSync_q) begin
                        rxCnt_q   <= halfBit(div_q);
                        rxState_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (rxTick) begin
                        if (rxSync_q) begin
                            rxState_q <= UART_IDLE;
                        end else begin
                            rxCnt_q   <= div_q;
                            rxBit_q   <= 3'd0;
                            rxState_q <= UART_DATA;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end
                end
                UART_DATA: begin
                    if (rxTick) begin
                        rxShift_q <= {rxSync_q, rxShift_q[7:1]};
                        rxCnt_q   <= div_q;
                        if (rxBit_q == 3'd7) begin
                            rxState_q <= UART_STOP;
                        end else begin
                            rxBit_q <= rxBit_q + 1'b1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end
                end
                UART_STOP: begin
                    if (rxTick) begin
                        rxState_q <= UART_IDLE;
                    end else begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Read mux; only a DATA read has a side effect (the FIFO pop above).
    always_comb begin
        o_dat = 16'h0000;
        if (rdAccess) begin
            case (i_addr)
                REG_DATA: begin
                    if (!rxEmpty) begin
                        o_dat = {8'h00, rxHead};
                    end
                end
                REG_STATUS: begin
                    o_dat[STAT_RX_AVAIL]     = !rxEmpty;
                    o_dat[STAT_RX_FULL]      = rxFull;
                    o_dat[STAT_TX_EMPTY]     = txIdleEmpty;
                    o_dat[STAT_TX_FULL]      = txFull;
                    o_dat[STAT_RX_OVERRUN]   = overrun_q;
                    o_dat[STAT_RX_FRAME_ERR] = frameErr_q;
                end
                REG_CTRL: begin
                    o_dat[1:0] = ctrl_q;
                end
                REG_DIV: begin
                    o_dat = div_q;
                end
                default: begin
                    o_dat = 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu_uart.sv
// Bench for dcpu_uart: a bus driver, a serial line driver, a behavioural
// model of the FIFOs/flags, and two monitors (bus reads, TX line decoder)
// that compare against queues of expected values.
module tb_dcpu_uart;

    localparam int          DEPTH   = 8;
    localparam logic [15:0] DIV_RST = 16'd433;
    localparam int          BITCLK  = 4;
    localparam logic [1:0]  A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdat = 16'h0;
    logic [15:0] rdat;
    logic        intr;
    logic        tx;
    logic        rxLine;
    logic        rxDrive = 1'b1;
    logic        loopback = 1'b0;

    assign rxLine = loopback ? tx : rxDrive;

    dcpu_uart #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_cs    (cs),
        .i_addr  (addr),
        .i_rw    (rw),
        .i_dat   (wdat),
        .o_dat   (rdat),
        .o_int   (intr),
        .i_rx    (rxLine),
        .o_tx    (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [15:0] e;
    } rdExp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txExpQ[$];
    rdExp_t      readQ[$];
    logic [7:0]  rxModelQ[$];
    bit          overrunM = 1'b0;
    bit          frameErrM = 1'b0;
    int          resetCount = 0;
    bit          monOn = 1'b0;

    rdExp_t      rdEnt;
    logic [7:0]  monByte;
    logic        monStop;
    int          monRc;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] statusExp(input bit txEmpty, input bit txFull);
        logic [15:0] s;
        s    = 16'h0;
        s[0] = (rxModelQ.size() != 0);
        s[1] = (rxModelQ.size() == DEPTH);
        s[2] = txEmpty;
        s[3] = txFull;
        s[4] = overrunM;
        s[5] = frameErrM;
        return s;
    endfunction

    // One bus cycle; for reads d is the expected read data.
    task automatic applyStimulus(input logic [1:0] a, input bit isRead, input logic [15:0] d);
        @(negedge clk);
        cs   = 1'b1;
        rw   = isRead;
        addr = a;
        wdat = isRead ? 16'h0 : d;
        if (isRead) begin
            readQ.push_back('{a, d});
        end else if (a == A_STATUS) begin
            if (d[4]) overrunM = 1'b0;
            if (d[5]) frameErrM = 1'b0;
        end
        @(negedge clk);
        cs = 1'b0;
        rw = 1'b0;
    endtask

    task automatic readData();
        logic [15:0] e;
        e = (rxModelQ.size() != 0) ? {8'h00, rxModelQ.pop_front()} : 16'h0000;
        applyStimulus(A_DATA, 1'b1, e);
    endtask

    task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxDrive = bits[i];
            repeat (BITCLK) @(negedge clk);
        end
        rxDrive = 1'b1;
        repeat (6) @(negedge clk);
        if (!stopBit) frameErrM = 1'b1;
        else if (rxModelQ.size() < DEPTH) rxModelQ.push_back(b);
        else overrunM = 1'b1;
    endtask

    task automatic waitTxDrain(input int limit);
        int n;
        n = 0;
        while (txExpQ.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tx frames outstanding", 16'(txExpQ.size()), 16'd0);
        repeat (6) @(negedge clk);
    endtask

    // Bus read monitor: compares o_dat mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (cs && rw) begin
                if (readQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL read unexpected: got %h, expected none", rdat);
                end else begin
                    rdEnt = readQ.pop_front();
                    checkOutput($sformatf("read reg%0d", rdEnt.a), rdat, rdEnt.e);
                end
            end
        end
    end

    // TX line monitor: decodes frames at mid-bit (DIV = 3) and compares bytes.
    initial begin
        wait (monOn);
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                monRc = resetCount;
                @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (BITCLK) @(negedge clk);
                    monByte[k] = tx;
                end
                repeat (BITCLK) @(negedge clk);
                monStop = tx;
                if (monRc == resetCount) begin
                    if (txExpQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL tx frame unexpected: got %h, expected none", monByte);
                    end else begin
                        checkOutput("tx frame", {7'b0, monStop, monByte}, {8'h01, txExpQ.pop_front()});
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  b;
        logic [9:0]  a5Bits;
        logic [7:0]  sent[$];
        int          bad;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset o_tx", {15'b0, tx}, 16'd1);
        checkOutput("reset o_int", {15'b0, intr}, 16'd0);
        monOn = 1'b1;
        applyStimulus(A_DIV, 1'b1, DIV_RST);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        applyStimulus(A_CTRL, 1'b1, 16'h0);
        readData();

        // Exact TX waveform for 0xA5 at four clocks per bit.
        applyStimulus(A_DIV, 1'b0, 16'd3);
        applyStimulus(A_DIV, 1'b1, 16'd3);
        txExpQ.push_back(8'hA5);
        applyStimulus(A_DATA, 1'b0, 16'h00A5);
        checkOutput("tx latency idle", {15'b0, tx}, 16'd1);
        a5Bits = {1'b1, 8'hA5, 1'b0};
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== a5Bits[i / BITCLK]) bad++;
        end
        checkOutput("A5 waveform bad samples", 16'(bad), 16'd0);
        repeat (2) @(negedge clk);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        waitTxDrain(100);

        // Loopback: single byte then a random burst.
        loopback = 1'b1;
        txExpQ.push_back(8'h3C);
        applyStimulus(A_DATA, 1'b0, 16'h003C);
        waitTxDrain(200);
        rxModelQ.push_back(8'h3C);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        readData();
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        sent.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            txExpQ.push_back(b);
            applyStimulus(A_DATA, 1'b0, {8'h00, b});
        end
        waitTxDrain(600);
        foreach (sent[i]) rxModelQ.push_back(sent[i]);
        for (int i = 0; i < 6; i++) readData();
        loopback = 1'b0;

        // Nine received bytes with no reads: full and overrun.
        for (int i = 0; i < 9; i++) sendRxFrame(8'($urandom_range(0, 255)), 1'b1);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        for (int i = 0; i < 8; i++) readData();
        readData();
        applyStimulus(A_STATUS, 1'b0, 16'h0010);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));

        // Framing error, then a short glitch that must push nothing.
        sendRxFrame(8'($urandom_range(0, 255)), 1'b0);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        applyStimulus(A_STATUS, 1'b0, 16'h0020);
        @(negedge clk);
        rxDrive = 1'b0;
        @(negedge clk);
        rxDrive = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        readData();

        // Interrupts and TX FIFO overflow.
        applyStimulus(A_CTRL, 1'b0, 16'h0003);
        checkOutput("int tx idle", {15'b0, intr}, 16'd1);
        b = 8'($urandom_range(0, 255));
        txExpQ.push_back(b);
        applyStimulus(A_DATA, 1'b0, {8'h00, b});
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < DEPTH) txExpQ.push_back(b);
            applyStimulus(A_DATA, 1'b0, {8'h00, b});
        end
        checkOutput("int tx busy", {15'b0, intr}, 16'd0);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b0, 1'b1));
        waitTxDrain(1000);
        checkOutput("int tx drained", {15'b0, intr}, 16'd1);
        applyStimulus(A_CTRL, 1'b0, 16'h0001);
        checkOutput("int rx en empty", {15'b0, intr}, 16'd0);
        sendRxFrame(8'($urandom_range(0, 255)), 1'b1);
        checkOutput("int rx avail", {15'b0, intr}, 16'd1);
        readData();
        checkOutput("int rx popped", {15'b0, intr}, 16'd0);
        applyStimulus(A_CTRL, 1'b1, 16'h0001);

        // Reset in the middle of a frame with bytes still queued.
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            txExpQ.push_back(b);
            applyStimulus(A_DATA, 1'b0, {8'h00, b});
        end
        repeat (10) @(negedge clk);
        reset = 1'b1;
        resetCount++;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid-frame reset o_tx", {15'b0, tx}, 16'd1);
        checkOutput("mid-frame reset o_int", {15'b0, intr}, 16'd0);
        txExpQ.delete();
        rxModelQ.delete();
        overrunM = 1'b0;
        frameErrM = 1'b0;
        applyStimulus(A_DIV, 1'b1, DIV_RST);
        applyStimulus(A_CTRL, 1'b1, 16'h0);
        applyStimulus(A_STATUS, 1'b1, statusExp(1'b1, 1'b0));
        readData();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        checkOutput("tx quiet after reset", 16'(bad), 16'd0);
        checkOutput("reads outstanding", 16'(readQ.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
